l2_pmem_burst_responder: RTL and testbench
==========================================

// Module: l2_pmem_burst_responder
// PURPOSE
//  Responder side of the L2 physical-memory interface (pmem_*): services whole-line
//  pmem_read/pmem_write requests from the L2 cache control. Each 256-bit line moves as
//  a 4-beat x 64-bit burst on the narrow main-memory bus. Returns one pmem_resp pulse
//  per completed line. Sits between L2 cache datapath/control and the memory model/arbiter.
// PARAMETERS
//  LINE_W   256  cache line width in bits (32-byte line, address bits [4:0] = offset)
//  BEAT_W   64   memory bus data width; BEATS = LINE_W/BEAT_W = 4, beat stride 8 bytes
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  pmem_address   in   16      line address from L2; [4:0] ignored
//  pmem_read      in   1       line read request, held by L2 until pmem_resp
//  pmem_write     in   1       line write request, held by L2 until pmem_resp
//  pmem_wdata     in   LINE_W  write line, valid while pmem_write high
//  pmem_rdata     out  LINE_W  assembled read line, valid in pmem_resp cycle and after
//  pmem_resp      out  1       one-cycle completion pulse (read or write)
//  mbus_addr      out  16      beat byte address = {line_base[15:5], beat[1:0], 3'b000}
//  mbus_read      out  1       beat read strobe, held until mbus_ready
//  mbus_write     out  1       beat write strobe, held until mbus_ready
//  mbus_wdata     out  BEAT_W  write beat = line[64*beat +: 64]
//  mbus_rdata     in   BEAT_W  read beat, valid when mbus_ready & mbus_read
//  mbus_ready     in   1       beat complete this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, beat=0, addr/wdata/rdata regs=0; all outputs 0
//   (pmem_rdata=0, pmem_resp=0, mbus_*=0) immediately; partial burst abandoned, no resp.
//  FSM: IDLE, RD_BURST, WR_BURST, RESP. Strobes/resp decoded from state (glitch-free reg'd state).
//  IDLE: pmem_write -> latch {pmem_address[15:5],5'b0} and pmem_wdata, beat=0, go WR_BURST.
//   Else pmem_read -> latch address, beat=0, go RD_BURST. Both high: write wins (violation).
//  RD_BURST: mbus_read=1. On mbus_ready: rdata_reg[64*beat +: 64] <= mbus_rdata, beat++;
//   at beat==3 & ready -> RESP. No ready: hold addr/strobe, stay.
//  WR_BURST: mbus_write=1, mbus_wdata from latched line (L2 changes to pmem_wdata ignored).
//   On ready beat++; beat==3 & ready -> RESP.
//  RESP: pmem_resp=1 for exactly one cycle, pmem_rdata = full new line; -> IDLE unconditionally.
//  IDLE re-samples requests the cycle after RESP, so back-to-back write-back then fill
//   (pmem_write resp followed next cycle by pmem_read) gives one dead cycle between bursts.
//  Latency: request first seen in IDLE at cycle N, mbus_ready tied 1 -> beats N+1..N+4,
//   pmem_resp at N+5. Each mbus_ready-low cycle adds one cycle.
//  pmem_rdata holds last read line until first beat of next read burst overwrites beat 0;
//   write bursts never modify it.
//  Request dropped mid-burst: burst still completes, pmem_resp still pulses.
//  Beat counter 2-bit, wraps 3->0 only at burst end; mbus_addr never crosses line boundary.
//  mbus_read and mbus_write never high together; both 0 in IDLE/RESP.
// STRUCTURE
//  lc3b_types additions: lc3b_c_block (logic [255:0]), lc3b_mem_beat (logic [63:0]),
//  lc3b_beat_idx (logic [1:0]), constant LC3B_BEATS_PER_LINE = 4.
//  Single module, no sub-modules; FSM + beat counter + address/wdata/rdata regs.
// TESTING
//  1 Read, ready=1, addr 16'h1234, beats 64'hA0..A3 -> mbus_addr 1220,1228,1230,1238;
//    resp at N+5; pmem_rdata = {A3,A2,A1,A0}.
//  2 Write line 256'h..., ready low 2 cycles on beat 1 -> mbus_wdata 4 slices in order,
//    beat 1 held 3 cycles, resp at N+7; pmem_rdata unchanged.
//  3 Write-back then fill: pmem_write resp, pmem_read next cycle -> exactly one idle cycle,
//    then read burst; exactly two resp pulses total.
//  4 pmem_read & pmem_write both high in IDLE -> WR_BURST only, mbus_read never asserts.
//  5 rst_n low during beat 2 of read -> all outputs 0 same cycle, no pmem_resp; new read
//    after release starts at beat 0.
//  6 L2 drops pmem_read after beat 1 -> burst finishes, single resp pulse, FSM back in IDLE.

Source files
------------

// File: rtl/l2_pmem_burst_responder_pkg.sv
// rtl/l2_pmem_burst_responder_pkg.sv - shared types and constants for the L2 pmem burst responder
package l2_pmem_burst_responder_pkg;

   localparam int LC3B_LINE_W         = 256;
   localparam int LC3B_BEAT_W         = 64;
   localparam int LC3B_BEATS_PER_LINE = 4;

   typedef logic [255:0] lc3b_c_block;
   typedef logic [63:0]  lc3b_mem_beat;
   typedef logic [1:0]   lc3b_beat_idx;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2,
      ST_RESP     = 2'd3
   } pmem_state_e;

   // Beat byte address inside a line; the beat index never carries into the line bits.
   function automatic logic [15:0] beat_addr(input logic [15:0] line_base, input lc3b_beat_idx beat);
      return {line_base[15:5], beat, 3'b000};
   endfunction

endpackage

// File: rtl/l2_pmem_burst_responder.sv
// rtl/l2_pmem_burst_responder.sv - services whole-line L2 pmem requests as 4-beat bursts on the memory bus
module l2_pmem_burst_responder
   import l2_pmem_burst_responder_pkg::*;
#(
   parameter int LINE_W = LC3B_LINE_W,
   parameter int BEAT_W = LC3B_BEAT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       pmem_address,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic [15:0]       mbus_addr,
   output logic              mbus_read,
   output logic              mbus_write,
   output logic [BEAT_W-1:0] mbus_wdata,
   input  logic [BEAT_W-1:0] mbus_rdata,
   input  logic              mbus_ready
);

   localparam lc3b_beat_idx LAST_BEAT = lc3b_beat_idx'(LC3B_BEATS_PER_LINE - 1);

   pmem_state_e       state;
   lc3b_beat_idx      beat;
   logic [15:0]       addr_reg;
   logic [LINE_W-1:0] wdata_reg;
   logic [LINE_W-1:0] rdata_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         beat      <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A simultaneous read and write is illegal; the write-back is served.
               if (pmem_write) begin
                  addr_reg  <= {pmem_address[15:5], 5'b0};
                  wdata_reg <= pmem_wdata;
                  beat      <= '0;
                  state     <= ST_WR_BURST;
               end else if (pmem_read) begin
                  addr_reg  <= {pmem_address[15:5], 5'b0};
                  beat      <= '0;
                  state     <= ST_RD_BURST;
               end
            end
            ST_RD_BURST: begin
               if (mbus_ready) begin
                  rdata_reg[BEAT_W*int'(beat) +: BEAT_W] <= mbus_rdata;
                  beat <= beat + 2'd1;
                  if (beat == LAST_BEAT) state <= ST_RESP;
               end
            end
            ST_WR_BURST: begin
               if (mbus_ready) begin
                  beat <= beat + 2'd1;
                  if (beat == LAST_BEAT) state <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes come straight off the state register so they cannot glitch.
   assign mbus_read  = (state == ST_RD_BURST);
   assign mbus_write = (state == ST_WR_BURST);
   assign pmem_resp  = (state == ST_RESP);
   assign mbus_addr  = beat_addr(addr_reg, beat) | {11'b0, addr_reg[4:0]};
   assign mbus_wdata = wdata_reg[BEAT_W*int'(beat) +: BEAT_W];
   assign pmem_rdata = rdata_reg;

endmodule

// File: tb/tb_l2_pmem_burst_responder.sv
// tb/tb_l2_pmem_burst_responder.sv - randomized self-checking bench against a line/beat memory model
module tb_l2_pmem_burst_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [15:0]  mbus_addr;
   logic         mbus_read;
   logic         mbus_write;
   logic [63:0]  mbus_wdata;
   logic [63:0]  mbus_rdata;
   logic         mbus_ready;

   int checks = 0;
   int errors = 0;
   int resp_count = 0;
   logic [255:0] last_read = '0;
   logic [63:0]  mem [int];

   always #5 clk = ~clk;

   l2_pmem_burst_responder dut (
      .clk(clk), .rst_n(rst_n),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .mbus_addr(mbus_addr), .mbus_read(mbus_read), .mbus_write(mbus_write),
      .mbus_wdata(mbus_wdata), .mbus_rdata(mbus_rdata), .mbus_ready(mbus_ready)
   );

   always @(negedge clk) if (pmem_resp) resp_count++;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_rd(input int idx);
      logic [15:0] k;
      k = idx[15:0];
      if (mem.exists(idx)) return mem[idx];
      return {k, ~k, 16'h5A5A, k ^ 16'h1234};
   endfunction

   // One line transfer seen from L2: memory answers with random stalls, beats are checked
   // against the line geometry, and the response against the memory model.
   task automatic run_line(input bit wr, input bit both, input logic [15:0] addr,
                           input logic [255:0] line, input int pct, input int fbeat,
                           input int fn, input int dead, input bit drop);
      int beats = 0, stalls = 0, cycles = 0, cur = 0, idx;
      bit done = 0;
      logic [15:0]  base;
      logic [255:0] exp_line;
      base = {addr[15:5], 5'b0};
      pmem_address = addr;
      pmem_wdata   = line;
      pmem_write   = wr;
      pmem_read    = !wr || both;
      mbus_ready   = 1'b0;
      while (!done) begin
         @(posedge clk); #1;
         cycles++;
         if (cycles > 300) begin
            check("timeout", 1, 0);
            done = 1;
         end else if (pmem_resp) begin
            check("latency", cycles, 5 + stalls + dead);
            check("beat_count", beats, 4);
            if (!wr) begin
               for (int b = 0; b < 4; b++) exp_line[64*b +: 64] = mem_rd(int'(base >> 3) + b);
               last_read = exp_line;
            end
            check("pmem_rdata", pmem_rdata, last_read);
            pmem_read = 0; pmem_write = 0; mbus_ready = 0;
            done = 1;
         end else if (cycles <= dead) begin
            check("dead_strobes", {mbus_read, mbus_write}, 2'b00);
            mbus_ready = 0;
         end else if (beats > 3) begin
            check("beat_overrun", beats, 3);
            done = 1;
         end else begin
            check("mbus_read", mbus_read, !wr);
            check("mbus_write", mbus_write, wr);
            check("mbus_addr", mbus_addr, 16'(base + beats * 8));
            if (wr) check("mbus_wdata", mbus_wdata, line[64*beats +: 64]);
            if (fbeat == beats && cur < fn) mbus_ready = 0;
            else mbus_ready = ($urandom_range(0, 99) >= pct);
            idx = int'(base >> 3) + beats;
            mbus_rdata = mem_rd(idx);
            if (mbus_ready) begin
               if (wr) mem[idx] = line[64*beats +: 64];
               beats++;
               cur = 0;
            end else begin
               stalls++;
               cur++;
            end
            if (drop && beats >= 2) pmem_read = 0;
            if (wr && $urandom_range(0, 1) == 1) pmem_wdata = {8{$urandom}};
         end
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   initial begin
      int rc;
      rst_n = 0; pmem_address = '0; pmem_read = 0; pmem_write = 0;
      pmem_wdata = '0; mbus_rdata = '0; mbus_ready = 0;
      #1;
      check("reset_outputs", {pmem_rdata, pmem_resp, mbus_addr, mbus_read, mbus_write, mbus_wdata}, '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;

      // Directed read with beats A0..A3, no stalls.
      for (int i = 0; i < 4; i++) mem[(16'h1220 >> 3) + i] = 64'hA0 + 64'(i);
      run_line(0, 0, 16'h1234, '0, 0, -1, 0, 0, 0);
      check("t1_line", pmem_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
      @(posedge clk); #1;

      // Write with two stall cycles on beat 1.
      run_line(1, 0, 16'h2260, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                               64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001}, 0, 1, 2, 0, 0);
      @(posedge clk); #1;

      // Write-back then fill back to back: one dead cycle, two responses.
      rc = resp_count;
      run_line(1, 0, 16'h3300, rand_line(), 20, -1, 0, 0, 0);
      run_line(0, 0, 16'h3300, '0, 20, -1, 0, 1, 0);
      @(posedge clk); #1;
      check("t3_resp_pulses", resp_count - rc, 2);
      check("t3_resp_low", pmem_resp, 0);

      // Read and write together: only the write burst runs.
      run_line(1, 1, 16'h0840, rand_line(), 10, -1, 0, 0, 0);
      @(posedge clk); #1;

      // Reset during beat 2 of a read.
      pmem_address = 16'h4440; pmem_read = 1; mbus_ready = 1; mbus_rdata = 64'hDEAD_BEEF_0000_0001;
      repeat (3) @(posedge clk);
      #1;
      check("t5_beat2_addr", mbus_addr, 16'h4450);
      rc = resp_count;
      rst_n = 0;
      #1;
      check("t5_async_zero", {pmem_rdata, pmem_resp, mbus_addr, mbus_read, mbus_write, mbus_wdata}, '0);
      pmem_read = 0; mbus_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      check("t5_no_resp", resp_count - rc, 0);
      last_read = '0;
      @(posedge clk); #1;
      run_line(0, 0, 16'h4440, '0, 25, -1, 0, 0, 0);
      @(posedge clk); #1;

      // Read dropped after beat 1 still completes once.
      rc = resp_count;
      run_line(0, 0, 16'h1234, '0, 20, -1, 0, 0, 1);
      @(posedge clk); #1;
      check("t6_idle_strobes", {mbus_read, mbus_write, pmem_resp}, 3'b000);
      @(posedge clk); #1;
      check("t6_stays_idle", {mbus_read, mbus_write, pmem_resp}, 3'b000);
      check("t6_one_resp", resp_count - rc, 1);

      // Random traffic over a few lines so reads observe earlier write-backs.
      for (int t = 0; t < 40; t++) begin
         logic [15:0] a;
         bit w;
         int gap;
         a = 16'h6000 | 16'($urandom_range(0, 7) << 5) | 16'($urandom_range(0, 31));
         w = ($urandom_range(0, 1) == 1);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
         run_line(w, w && ($urandom_range(0, 3) == 0), a, rand_line(), 35, -1, 0,
                  (gap == 0) ? 1 : 0, !w && ($urandom_range(0, 3) == 0));
      end
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
